// File: rtl/npu_definitions.sv
// Shared NoC definitions: flit width, header field offsets, packetizer FSM encoding
// and the buffered message record.
package npu_definitions;

    localparam int FLIT_W    = 16;
    localparam int NODE_ID_W = 6;
    localparam int LEN_W     = 2;
    localparam int SEQ_W     = 2;
    localparam int PAYLOAD_W = 64;

    localparam int HDR_DEST_LSB = 10;
    localparam int HDR_SRC_LSB  = 4;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_SEQ_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } pkt_state_e;

    // dest and len sit at the top so the buffer can expose them for the next entry.
    typedef struct packed {
        logic [NODE_ID_W-1:0] dest;
        logic [LEN_W-1:0]     len;
        logic [PAYLOAD_W-1:0] data;
    } msg_t;

    localparam int MSG_W  = $bits(msg_t);
    localparam int PEEK_W = NODE_ID_W + LEN_W;

    function automatic logic [FLIT_W-1:0] make_header(
        input logic [NODE_ID_W-1:0] dest,
        input logic [NODE_ID_W-1:0] src,
        input logic [LEN_W-1:0]     len,
        input logic [SEQ_W-1:0]     seq
    );
        logic [FLIT_W-1:0] hdr;
        hdr = '0;
        hdr[HDR_DEST_LSB +: NODE_ID_W] = dest;
        hdr[HDR_SRC_LSB  +: NODE_ID_W] = src;
        hdr[HDR_LEN_LSB  +: LEN_W]     = len;
        hdr[HDR_SEQ_LSB  +: SEQ_W]     = seq;
        return hdr;
    endfunction

    function automatic logic [FLIT_W-1:0] payload_flit(
        input logic [PAYLOAD_W-1:0] data,
        input logic [LEN_W-1:0]     idx
    );
        logic [FLIT_W-1:0] flit;
        case (idx)
            2'd0:    flit = data[15:0];
            2'd1:    flit = data[31:16];
            2'd2:    flit = data[47:32];
            default: flit = data[63:48];
        endcase
        return flit;
    endfunction

endpackage

// File: rtl/noc_msg_fifo.sv
// Synchronous message FIFO with full/empty flags; also exposes the header fields
// of the entry behind the head so a following packet can start without a bubble.
module noc_msg_fifo
    import npu_definitions::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = MSG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_pop,
    output logic [WIDTH-1:0]  o_head,
    output logic [PEEK_W-1:0] o_next_peek,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_multi
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW-1:0]    w_rd_ptr_nxt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full       = (r_count == CW'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign o_multi      = (r_count > CW'(1));
    assign w_do_push    = i_push && !o_full;
    assign w_do_pop     = i_pop && !o_empty;
    assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;
    assign o_head       = r_mem[r_rd_ptr];
    assign o_next_peek  = r_mem[w_rd_ptr_nxt][WIDTH-1 -: PEEK_W];

    // NOTE: the storage array is not reset; the pointers and count alone define
    // which entries are valid, so clearing it would add nothing but reset fanout.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state uses <= so every register sees pre-edge values
    // no matter how the always blocks are ordered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= w_rd_ptr_nxt;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/noc_packetizer.sv
// Turns buffered 64-bit messages into header + 1..4 payload flits for a NoC router,
// with registered flit outputs and back-to-back packet issue.
module noc_packetizer
    import npu_definitions::*;
#(
    parameter int MSG_DEPTH = 2,
    parameter int SRC_ID_W  = NODE_ID_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SRC_ID_W-1:0] router_id,
    input  logic [63:0]         msg_data,
    input  logic [SRC_ID_W-1:0] msg_dest,
    input  logic [1:0]          msg_len,
    input  logic                msg_valid,
    output logic                msg_ready,
    output logic [15:0]         flit_data,
    output logic [SRC_ID_W-1:0] flit_dest,
    output logic                flit_last,
    output logic                flit_valid,
    input  logic                flit_ready,
    output logic [15:0]         pkt_count
);

    pkt_state_e             r_state, w_state_next;
    logic [FLIT_W-1:0]      r_flit_data, w_data_next;
    logic [NODE_ID_W-1:0]   r_flit_dest, w_dest_next;
    logic                   r_flit_last, w_last_next;
    logic                   r_flit_valid, w_valid_next;
    logic [LEN_W-1:0]       r_idx, w_idx_next;
    logic [SEQ_W-1:0]       r_seq, w_seq_next;
    logic [15:0]            r_pkt_count, w_cnt_next;

    msg_t                   w_in_msg;
    msg_t                   w_head;
    logic [PEEK_W-1:0]      w_next_peek;
    logic                   w_full, w_empty, w_multi;
    logic                   w_push, w_pop, w_xfer, w_load_hdr;
    logic [NODE_ID_W-1:0]   w_hdr_dest;
    logic [LEN_W-1:0]       w_hdr_len;

    assign w_in_msg  = {msg_dest, msg_len, msg_data};
    assign msg_ready = !w_full && !rst;
    assign w_push    = msg_valid && msg_ready;
    assign w_xfer    = r_flit_valid && flit_ready;

    noc_msg_fifo #(
        .DEPTH (MSG_DEPTH),
        .WIDTH (MSG_W)
    ) u_msg_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_data      (w_in_msg),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_next_peek (w_next_peek),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_multi     (w_multi)
    );

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_valid_next = r_flit_valid;
        w_data_next  = r_flit_data;
        w_dest_next  = r_flit_dest;
        w_last_next  = r_flit_last;
        w_idx_next   = r_idx;
        w_seq_next   = r_seq;
        w_cnt_next   = r_pkt_count;
        w_pop        = 1'b0;
        w_load_hdr   = 1'b0;
        w_hdr_dest   = w_head.dest;
        w_hdr_len    = w_head.len;

        case (r_state)
            ST_IDLE: begin
                // An empty idle block takes the header straight from the input
                // so it is presented the cycle after acceptance.
                if (!w_empty) begin
                    w_load_hdr = 1'b1;
                end else if (w_push) begin
                    w_load_hdr = 1'b1;
                    w_hdr_dest = w_in_msg.dest;
                    w_hdr_len  = w_in_msg.len;
                end
            end
            ST_HEAD: begin
                if (w_xfer) begin
                    w_state_next = ST_BODY;
                    w_idx_next   = '0;
                    w_data_next  = payload_flit(w_head.data, 2'd0);
                    w_last_next  = (w_head.len == 2'd0);
                end
            end
            ST_BODY: begin
                if (w_xfer) begin
                    if (r_idx == w_head.len) begin
                        w_pop      = 1'b1;
                        w_seq_next = r_seq + 2'd1;
                        w_cnt_next = r_pkt_count + 16'd1;
                        if (w_multi) begin
                            w_load_hdr = 1'b1;
                            {w_hdr_dest, w_hdr_len} = w_next_peek;
                        end else if (w_push) begin
                            w_load_hdr = 1'b1;
                            w_hdr_dest = w_in_msg.dest;
                            w_hdr_len  = w_in_msg.len;
                        end else begin
                            w_state_next = ST_IDLE;
                            w_valid_next = 1'b0;
                            w_last_next  = 1'b0;
                        end
                    end else begin
                        w_idx_next  = r_idx + 2'd1;
                        w_data_next = payload_flit(w_head.data, r_idx + 2'd1);
                        w_last_next = ((r_idx + 2'd1) == w_head.len);
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (w_load_hdr) begin
            w_state_next = ST_HEAD;
            w_valid_next = 1'b1;
            w_last_next  = 1'b0;
            w_dest_next  = w_hdr_dest;
            w_data_next  = make_header(w_hdr_dest, router_id, w_hdr_len, w_seq_next);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_flit_valid <= 1'b0;
            r_flit_data  <= '0;
            r_flit_dest  <= '0;
            r_flit_last  <= 1'b0;
            r_idx        <= '0;
            r_seq        <= '0;
            r_pkt_count  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_flit_valid <= w_valid_next;
            r_flit_data  <= w_data_next;
            r_flit_dest  <= w_dest_next;
            r_flit_last  <= w_last_next;
            r_idx        <= w_idx_next;
            r_seq        <= w_seq_next;
            r_pkt_count  <= w_cnt_next;
        end
    end

    assign flit_valid = r_flit_valid;
    assign flit_data  = r_flit_data;
    assign flit_dest  = r_flit_dest;
    assign flit_last  = r_flit_last;
    assign pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed bench for noc_packetizer: table of single messages with hand-computed
// flits, then stall/backpressure, back-to-back seq wrap and mid-packet reset sequences.
module tb_noc_packetizer;

    logic        clk;
    logic        rst;
    logic [5:0]  router_id;
    logic [63:0] msg_data;
    logic [5:0]  msg_dest;
    logic [1:0]  msg_len;
    logic        msg_valid;
    logic        msg_ready;
    logic [15:0] flit_data;
    logic [5:0]  flit_dest;
    logic        flit_last;
    logic        flit_valid;
    logic        flit_ready;
    logic [15:0] pkt_count;

    noc_packetizer #(
        .MSG_DEPTH (2),
        .SRC_ID_W  (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .router_id  (router_id),
        .msg_data   (msg_data),
        .msg_dest   (msg_dest),
        .msg_len    (msg_len),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .flit_data  (flit_data),
        .flit_dest  (flit_dest),
        .flit_last  (flit_last),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .pkt_count  (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [15:0] rx_data [$];
    logic        rx_last [$];
    logic [5:0]  rx_dest [$];
    int          rx_cyc  [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && flit_valid && flit_ready) begin
            rx_data.push_back(flit_data);
            rx_last.push_back(flit_last);
            rx_dest.push_back(flit_dest);
            rx_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic [5:0]  dest;
        logic [1:0]  len;
        logic [63:0] data;
        logic [15:0] exp_flit [5];
    } vec_t;

    vec_t        vecs [5];
    logic [15:0] exp_a [10];
    logic [9:0]  exp_a_last;
    logic [15:0] exp_b_hdr [5];

    function automatic vec_t mk(input logic [5:0] d, input logic [1:0] l, input logic [63:0] data,
                                input logic [15:0] h, input logic [15:0] f0, input logic [15:0] f1,
                                input logic [15:0] f2, input logic [15:0] f3);
        vec_t v;
        v.dest = d;
        v.len  = l;
        v.data = data;
        v.exp_flit[0] = h;
        v.exp_flit[1] = f0;
        v.exp_flit[2] = f1;
        v.exp_flit[3] = f2;
        v.exp_flit[4] = f3;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic clear_rx();
        rx_data.delete();
        rx_last.delete();
        rx_dest.delete();
        rx_cyc.delete();
    endtask

    // Called just after a rising edge; returns just after the acceptance edge.
    task automatic send_msg(input logic [5:0] d, input logic [1:0] l, input logic [63:0] data);
        bit got;
        got       = 1'b0;
        msg_dest  = d;
        msg_len   = l;
        msg_data  = data;
        msg_valid = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (msg_ready) got = 1'b1;
        end
        @(posedge clk);
        #1;
        msg_valid = 1'b0;
        if (!got) check("send_accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_rx(input int n, input int max_cycles, input string name);
        for (int k = 0; k < max_cycles; k++) begin
            if (rx_data.size() >= n) break;
            @(negedge clk);
        end
        check(name, 64'(rx_data.size()), 64'(n));
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        msg_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_rx();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // router_id = 0x02 throughout; header = dest<<10 | 0x20 | len<<2 | seq
        vecs[0] = mk(6'h05, 2'd0, 64'h0000_0000_0000_1234, 16'h1420, 16'h1234, 16'h0, 16'h0, 16'h0);
        vecs[1] = mk(6'h0A, 2'd3, 64'h4444_3333_2222_1111, 16'h282D, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        vecs[2] = mk(6'h3F, 2'd1, 64'hDEAD_0000_BEEF_CAFE, 16'hFC26, 16'hCAFE, 16'hBEEF, 16'h0, 16'h0);
        vecs[3] = mk(6'h00, 2'd2, 64'h0000_9999_8888_7777, 16'h002B, 16'h7777, 16'h8888, 16'h9999, 16'h0);
        vecs[4] = mk(6'h15, 2'd0, 64'hFFFF_FFFF_FFFF_A5A5, 16'h5420, 16'hA5A5, 16'h0, 16'h0, 16'h0);

        exp_a = '{16'h042C, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D,
                  16'h0821, 16'h1B1B, 16'h0C26, 16'h2C2C, 16'h2D2D};
        exp_a_last = 10'b10_0101_0000;
        exp_b_hdr  = '{16'h1020, 16'h1021, 16'h1022, 16'h1023, 16'h1020};

        rst        = 1'b1;
        router_id  = 6'h02;
        msg_data   = '0;
        msg_dest   = '0;
        msg_len    = '0;
        msg_valid  = 1'b0;
        flit_ready = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_msg_ready",  64'(msg_ready),  64'(0));
        check("rst_flit_valid", 64'(flit_valid), 64'(0));
        check("rst_flit_data",  64'(flit_data),  64'(0));
        check("rst_flit_dest",  64'(flit_dest),  64'(0));
        check("rst_flit_last",  64'(flit_last),  64'(0));
        check("rst_pkt_count",  64'(pkt_count),  64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_msg_ready", 64'(msg_ready), 64'(1));
        @(posedge clk);
        #1;
        flit_ready = 1'b1;
        clear_rx();

        // ---- table: one message at a time into an idle block ----
        for (int i = 0; i < 5; i++) begin
            int n;
            n = int'(vecs[i].len) + 2;
            send_msg(vecs[i].dest, vecs[i].len, vecs[i].data);
            @(negedge clk);
            check($sformatf("v%0d_hdr_latency_valid", i), 64'(flit_valid), 64'(1));
            check($sformatf("v%0d_hdr_latency_data", i),  64'(flit_data),  64'(vecs[i].exp_flit[0]));
            wait_rx(n, 40, $sformatf("v%0d_flit_count", i));
            check($sformatf("v%0d_pkt_count", i), 64'(pkt_count), 64'(i + 1));
            check($sformatf("v%0d_idle_after", i), 64'(flit_valid), 64'(0));
            for (int j = 0; j < n; j++) begin
                if (j < rx_data.size()) begin
                    check($sformatf("v%0d_flit%0d_data", i, j), 64'(rx_data[j]), 64'(vecs[i].exp_flit[j]));
                    check($sformatf("v%0d_flit%0d_last", i, j), 64'(rx_last[j]), 64'(j == n - 1));
                    check($sformatf("v%0d_flit%0d_dest", i, j), 64'(rx_dest[j]), 64'(vecs[i].dest));
                end
            end
            @(posedge clk);
            #1;
            clear_rx();
        end

        // ---- stall mid-packet with three messages queued ----
        apply_reset();
        flit_ready = 1'b0;
        send_msg(6'h01, 2'd3, 64'h0D0D_0C0C_0B0B_0A0A);
        send_msg(6'h02, 2'd0, 64'h0000_0000_0000_1B1B);
        fork
            send_msg(6'h03, 2'd1, 64'h0000_0000_2D2D_2C2C);
            begin
                @(negedge clk);
                check("stall_full_msg_ready", 64'(msg_ready), 64'(0));
                check("stall_hdr_held", 64'(flit_data), 64'(16'h042C));
                @(posedge clk);
                #1;
                flit_ready = 1'b1;
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                flit_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check($sformatf("stall%0d_data", k),  64'(flit_data),  64'(16'h0B0B));
                    check($sformatf("stall%0d_valid", k), 64'(flit_valid), 64'(1));
                    check($sformatf("stall%0d_last", k),  64'(flit_last),  64'(0));
                    check($sformatf("stall%0d_dest", k),  64'(flit_dest),  64'(6'h01));
                    check($sformatf("stall%0d_ready", k), 64'(msg_ready),  64'(0));
                    @(posedge clk);
                    #1;
                end
                flit_ready = 1'b1;
                wait_rx(10, 100, "stall_flit_count");
            end
        join
        check("stall_pkt_count", 64'(pkt_count), 64'(3));
        check("stall_idle_after", 64'(flit_valid), 64'(0));
        for (int j = 0; j < 10; j++) begin
            if (j < rx_data.size()) begin
                check($sformatf("stall_flit%0d_data", j), 64'(rx_data[j]), 64'(exp_a[j]));
                check($sformatf("stall_flit%0d_last", j), 64'(rx_last[j]), 64'(exp_a_last[j]));
            end
        end
        @(posedge clk);
        #1;

        // ---- five back-to-back single-flit messages: seq wraps, no bubbles ----
        apply_reset();
        flit_ready = 1'b1;
        fork
            for (int i = 0; i < 5; i++) send_msg(6'h04, 2'd0, 64'hA000 + 64'(i));
            wait_rx(10, 200, "b2b_flit_count");
        join
        for (int i = 0; i < 5; i++) begin
            if (2 * i + 1 < rx_data.size()) begin
                check($sformatf("b2b%0d_hdr", i),  64'(rx_data[2*i]),     64'(exp_b_hdr[i]));
                check($sformatf("b2b%0d_data", i), 64'(rx_data[2*i+1]),   64'(16'hA000 + 16'(i)));
                check($sformatf("b2b%0d_last", i), 64'(rx_last[2*i+1]),   64'(1));
            end
        end
        for (int i = 0; i < 9; i++) begin
            if (i + 1 < rx_cyc.size()) begin
                check($sformatf("b2b_gap%0d", i), 64'(rx_cyc[i+1] - rx_cyc[i]), 64'(1));
            end
        end
        check("b2b_pkt_count", 64'(pkt_count), 64'(5));
        @(posedge clk);
        #1;

        // ---- reset during a BODY flit discards the packet and the queue ----
        apply_reset();
        flit_ready = 1'b1;
        send_msg(6'h0A, 2'd3, 64'h4444_3333_2222_1111);
        send_msg(6'h07, 2'd0, 64'h0000_0000_0000_5555);
        @(negedge clk);
        check("midrst_in_body_data", 64'(flit_data), 64'(16'h1111));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready_low", 64'(msg_ready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_flit_valid", 64'(flit_valid), 64'(0));
        check("midrst_pkt_count",  64'(pkt_count),  64'(0));
        check("midrst_flit_last",  64'(flit_last),  64'(0));
        check("midrst_ready_back", 64'(msg_ready),  64'(1));
        clear_rx();
        repeat (10) @(negedge clk);
        check("midrst_no_stale_flits", 64'(rx_data.size()), 64'(0));
        check("midrst_still_idle", 64'(flit_valid), 64'(0));
        @(posedge clk);
        #1;
        send_msg(6'h05, 2'd0, 64'h0000_0000_0000_1234);
        @(negedge clk);
        check("midrst_next_hdr_seq0", 64'(flit_data), 64'(16'h1420));
        wait_rx(2, 40, "midrst_next_flit_count");
        if (rx_data.size() >= 2) begin
            check("midrst_next_payload", 64'(rx_data[1]), 64'(16'h1234));
        end
        check("midrst_next_pkt_count", 64'(pkt_count), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
